// File: rtl/pcie_mgr_pkg.sv
// pcie_mgr_pkg
// Shared definitions for the PCIe link reset manager:
//   - mgr_state_e  : sequencer state encodings (also exported on mgr_state)
//   - LTSSM_L0_DEF : default phy_ltssm_state encoding of L0
//   - DROP_CNT_W   : width of the saturating link-drop counter
//   - max_int      : elaboration-time helper for sizing shared counters
package pcie_mgr_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_CORE_DLY  = 3'd2,
        ST_TRAIN     = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_RCVRY     = 3'd5
    } mgr_state_e;

    localparam logic [3:0] LTSSM_L0_DEF = 4'd3;
    localparam int         DROP_CNT_W   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcie_sync2.sv
// pcie_sync2
// Two-flop synchroniser, parametrised width. The flops reset asynchronously
// to RST_VAL, so when used on a reset line (d tied high) it gives an
// assert-async / deassert-sync reset.
// Ports:
//   clk   in  1      destination clock
//   rst_n in  1      asynchronous active-low reset
//   d     in  WIDTH  asynchronous input
//   q     out WIDTH  synchronised output
module pcie_sync2 #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{RST_VAL}};
            sync_q <= {WIDTH{RST_VAL}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcie_link_rst_mgr.sv
// pcie_link_rst_mgr
// Reset and link-management sequencer between the board reset pin, the
// PCS/SERDES PIPE wrapper and the PCIe core.
// Optional feature: define PCIE_LINK_WDOG_EN to build a training watchdog
// that restarts the core-reset delay if dl_up never arrives in TRAIN.
// Ports:
//   sys_clk_125      in   1          125 MHz core clock
//   rst_n            in   1          async active-low board reset
//   ffs_plol         in   1          PCS PLL loss of lock (async)
//   ffs_rlol         in   NUM_LANES  per-lane CDR loss of lock (async)
//   phy_ltssm_state  in   4          LTSSM state from core
//   dl_up            in   1          data link layer up
//   sw_retrain       in   1          single-cycle software retrain request
//   pcs_rst_n        out  1          reset to PIPE wrapper
//   core_rst_n       out  1          delayed reset to core / user logic
//   phy_l0           out  1          registered LTSSM == L0
//   hl_gto_rcvry     out  1          recovery request pulse
//   link_up          out  1          registered dl_up, only in LINK_UP
//   link_drop_cnt    out  8          saturating link-drop count
//   mgr_state        out  3          current sequencer state
module pcie_link_rst_mgr
    import pcie_mgr_pkg::*;
#(
    parameter int         NUM_LANES       = 1,
    parameter int         CORE_DLY_W      = 20,
    parameter int         LOCK_STABLE_CYC = 1024,
    parameter logic [3:0] LTSSM_L0        = LTSSM_L0_DEF,
    parameter int         RCVRY_PULSE_CYC = 4,
    parameter int         WDOG_W          = 24
) (
    input  logic                  sys_clk_125,
    input  logic                  rst_n,
    input  logic                  ffs_plol,
    input  logic [NUM_LANES-1:0]  ffs_rlol,
    input  logic [3:0]            phy_ltssm_state,
    input  logic                  dl_up,
    input  logic                  sw_retrain,
    output logic                  pcs_rst_n,
    output logic                  core_rst_n,
    output logic                  phy_l0,
    output logic                  hl_gto_rcvry,
    output logic                  link_up,
    output logic [DROP_CNT_W-1:0] link_drop_cnt,
    output logic [2:0]            mgr_state
);

    localparam int LOCK_W  = $clog2(LOCK_STABLE_CYC + 1);
    localparam int RCVRY_W = $clog2(RCVRY_PULSE_CYC + 1);
`ifdef PCIE_LINK_WDOG_EN
    localparam int WDOG_BITS = WDOG_W;
`else
    // Without the watchdog, TRAIN needs no counter bits.
    localparam int WDOG_BITS = 0 * WDOG_W;
`endif
    // One counter is shared by all states; it is cleared on every state change.
    localparam int CNT_W = max_int(max_int(CORE_DLY_W, LOCK_W), max_int(RCVRY_W, WDOG_BITS));

    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      LOCK_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]      RCVRY_LAST = CNT_W'(RCVRY_PULSE_CYC - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX   = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE   = DROP_CNT_W'(1);
`ifdef PCIE_LINK_WDOG_EN
    // Leaving on the edge where the watchdog would reach all-ones.
    localparam logic [WDOG_W-1:0]     WDOG_LAST  = {{(WDOG_W-1){1'b1}}, 1'b0};
`endif

    logic                  rst_sync_n;
    logic                  plol_s;
    logic [NUM_LANES-1:0]  rlol_s;
    logic                  lock_ok;
    logic                  dl_up_fall;
    logic                  cnt_clr;
    logic                  cnt_inc;

    mgr_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  dl_up_q;
    logic                  pcs_rst_n_q, pcs_rst_n_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  phy_l0_q, phy_l0_d;
    logic                  rcvry_q, rcvry_d;
    logic                  link_up_q, link_up_d;

    pcie_sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_rst_sync (
        .clk   (sys_clk_125),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    // Lock synchronisers leave reset reading "locked"; LOCK_WAIT still
    // demands LOCK_STABLE_CYC clean cycles, which covers the first two.
    pcie_sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_plol_sync (
        .clk   (sys_clk_125),
        .rst_n (rst_sync_n),
        .d     (ffs_plol),
        .q     (plol_s)
    );

    pcie_sync2 #(.WIDTH(NUM_LANES), .RST_VAL(1'b0)) u_rlol_sync (
        .clk   (sys_clk_125),
        .rst_n (rst_sync_n),
        .d     (ffs_rlol),
        .q     (rlol_s)
    );

    assign lock_ok    = ~plol_s & ~(|rlol_s);
    assign dl_up_fall = dl_up_q & ~dl_up;

    // Next-state, counter and output decode; lock loss outranks every link event.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (!lock_ok) begin
                    cnt_clr = 1'b1;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_CORE_DLY;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_CORE_DLY: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                end else if (cnt_q[CORE_DLY_W-1]) begin
                    state_d = ST_TRAIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_TRAIN: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                end else if (dl_up) begin
                    state_d = ST_LINK_UP;
`ifdef PCIE_LINK_WDOG_EN
                end else if (cnt_q[WDOG_W-1:0] == WDOG_LAST) begin
                    state_d = ST_CORE_DLY;
                end else begin
                    cnt_inc = 1'b1;
                end
`else
                end else begin
                    state_d = ST_TRAIN;
                end
`endif
            end
            ST_LINK_UP: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                end else if (dl_up_fall) begin
                    state_d    = ST_RCVRY;
                    drop_cnt_d = (drop_cnt_q == DROP_MAX) ? drop_cnt_q : (drop_cnt_q + DROP_ONE);
                end else if (sw_retrain) begin
                    state_d = ST_RCVRY;
                end else begin
                    state_d = ST_LINK_UP;
                end
            end
            ST_RCVRY: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                end else if (cnt_q == RCVRY_LAST) begin
                    state_d = ST_TRAIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        cnt_d = (cnt_clr || (state_d != state_q)) ? CNT_ZERO
              : (cnt_inc ? (cnt_q + CNT_ONE) : cnt_q);

        // Outputs follow the next state so they change on the same edge as mgr_state.
        pcs_rst_n_d  = (state_d != ST_RESET);
        core_rst_n_d = (state_d == ST_TRAIN) || (state_d == ST_LINK_UP) || (state_d == ST_RCVRY);
        rcvry_d      = (state_d == ST_RCVRY);
        link_up_d    = dl_up && (state_d == ST_LINK_UP);
        phy_l0_d     = (phy_ltssm_state == LTSSM_L0);
    end

    // State, counters and registered outputs, all cleared by the synchronised reset.
    always_ff @(posedge sys_clk_125 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= ST_RESET;
            cnt_q        <= CNT_ZERO;
            drop_cnt_q   <= {DROP_CNT_W{1'b0}};
            dl_up_q      <= 1'b0;
            pcs_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            phy_l0_q     <= 1'b0;
            rcvry_q      <= 1'b0;
            link_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            dl_up_q      <= dl_up;
            pcs_rst_n_q  <= pcs_rst_n_d;
            core_rst_n_q <= core_rst_n_d;
            phy_l0_q     <= phy_l0_d;
            rcvry_q      <= rcvry_d;
            link_up_q    <= link_up_d;
        end
    end

    assign pcs_rst_n     = pcs_rst_n_q;
    assign core_rst_n    = core_rst_n_q;
    assign phy_l0        = phy_l0_q;
    assign hl_gto_rcvry  = rcvry_q;
    assign link_up       = link_up_q;
    assign link_drop_cnt = drop_cnt_q;
    assign mgr_state     = state_q;

endmodule

// File: tb/tb_pcie_link_rst_mgr.sv
// tb_pcie_link_rst_mgr
// Directed bench for pcie_link_rst_mgr with NUM_LANES=4, CORE_DLY_W=8,
// LOCK_STABLE_CYC=64, WDOG_W=6. The watchdog sequence is built only when
// PCIE_LINK_WDOG_EN is defined.
module tb_pcie_link_rst_mgr;

    localparam int L_STABLE = 64;
    localparam int DLY_W    = 8;
    // Edge (counted from rst_n release) on which core_rst_n rises with clean locks.
    localparam int T_CORE   = 3 + L_STABLE + (1 << (DLY_W - 1)) + 1;

    logic       sys_clk_125 = 1'b0;
    logic       rst_n       = 1'b0;
    logic       ffs_plol    = 1'b0;
    logic [3:0] ffs_rlol    = 4'd0;
    logic [3:0] phy_ltssm_state = 4'd0;
    logic       dl_up       = 1'b0;
    logic       sw_retrain  = 1'b0;
    logic       pcs_rst_n;
    logic       core_rst_n;
    logic       phy_l0;
    logic       hl_gto_rcvry;
    logic       link_up;
    logic [7:0] link_drop_cnt;
    logic [2:0] mgr_state;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] ltssm;
        logic       dl;
        logic       sw;
        logic       exp_l0;
        logic [2:0] exp_state;
        logic       exp_lu;
        logic       exp_hl;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t vecs[11];

    pcie_link_rst_mgr #(
        .NUM_LANES       (4),
        .CORE_DLY_W      (DLY_W),
        .LOCK_STABLE_CYC (L_STABLE),
        .LTSSM_L0        (4'd3),
        .RCVRY_PULSE_CYC (4),
        .WDOG_W          (6)
    ) dut (
        .sys_clk_125     (sys_clk_125),
        .rst_n           (rst_n),
        .ffs_plol        (ffs_plol),
        .ffs_rlol        (ffs_rlol),
        .phy_ltssm_state (phy_ltssm_state),
        .dl_up           (dl_up),
        .sw_retrain      (sw_retrain),
        .pcs_rst_n       (pcs_rst_n),
        .core_rst_n      (core_rst_n),
        .phy_l0          (phy_l0),
        .hl_gto_rcvry    (hl_gto_rcvry),
        .link_up         (link_up),
        .link_drop_cnt   (link_drop_cnt),
        .mgr_state       (mgr_state)
    );

    always #4 sys_clk_125 = ~sys_clk_125;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge sys_clk_125);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_pcs_rst_n"},  pcs_rst_n,     0);
        check({tag, "_core_rst_n"}, core_rst_n,    0);
        check({tag, "_phy_l0"},     phy_l0,        0);
        check({tag, "_hl_rcvry"},   hl_gto_rcvry,  0);
        check({tag, "_link_up"},    link_up,       0);
        check({tag, "_drop_cnt"},   link_drop_cnt, 0);
        check({tag, "_state"},      mgr_state,     0);
    endtask

    // Hold reset 10 cycles with idle inputs, check reset outputs, then release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        ffs_plol = 1'b0;
        ffs_rlol = 4'd0;
        dl_up = 1'b0;
        sw_retrain = 1'b0;
        phy_ltssm_state = 4'd0;
        repeat (10) step();
        check_reset_outs(tag);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        int g;
        int to_err;

        //            ltssm  dl    sw    l0    state lu    hl    drop
        vecs[0]  = '{4'd0,  1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{4'd3,  1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{4'd3,  1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{4'd4,  1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{4'd3,  1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 8'd0};
        vecs[5]  = '{4'd2,  1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 8'd0};
        vecs[6]  = '{4'd3,  1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 8'd0};
        vecs[7]  = '{4'd0,  1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 8'd0};
        vecs[8]  = '{4'd3,  1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{4'd15, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0};
        vecs[10] = '{4'd3,  1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 8'd1};

        // Power-on with clean locks.
        do_reset("por");
        run_to(2);
        check("por_pcs_c2", pcs_rst_n, 0);
        check("por_state_c2", mgr_state, 0);
        run_to(3);
        check("por_pcs_c3", pcs_rst_n, 1);
        check("por_state_c3", mgr_state, 1);
        run_to(T_CORE - 1);
        check("por_core_early", core_rst_n, 0);
        check("por_state_dly", mgr_state, 2);
        run_to(T_CORE);
        check("por_core_rel", core_rst_n, 1);
        check("por_state_train", mgr_state, 3);

        // One-cycle lane-1 CDR glitch halfway through LOCK_WAIT.
        do_reset("glitch");
        run_to(3 + L_STABLE / 2 - 1);
        ffs_rlol = 4'b0010;
        step();
        ffs_rlol = 4'd0;
        run_to(3 + L_STABLE);
        check("glitch_no_early_dly", mgr_state, 1);
        run_to(3 + L_STABLE / 2 + 2 + L_STABLE - 1);
        check("glitch_still_wait", mgr_state, 1);
        step();
        check("glitch_dly_entry", mgr_state, 2);
        run_to(3 + L_STABLE / 2 + 2 + L_STABLE + (1 << (DLY_W - 1)) + 1);
        check("glitch_core_rel", core_rst_n, 1);
        check("glitch_train", mgr_state, 3);

        // Table-driven vectors starting in TRAIN.
        for (int i = 0; i < 11; i++) begin
            phy_ltssm_state = vecs[i].ltssm;
            dl_up = vecs[i].dl;
            sw_retrain = vecs[i].sw;
            step();
            check($sformatf("vec%0d_phy_l0", i), phy_l0, vecs[i].exp_l0);
            check($sformatf("vec%0d_state", i), mgr_state, vecs[i].exp_state);
            check($sformatf("vec%0d_link_up", i), link_up, vecs[i].exp_lu);
            check($sformatf("vec%0d_hl_rcvry", i), hl_gto_rcvry, vecs[i].exp_hl);
            check($sformatf("vec%0d_drop_cnt", i), link_drop_cnt, vecs[i].exp_drop);
        end
        sw_retrain = 1'b0;

        // Recovery pulse width after the link drop of the last vector.
        hi = 1;
        g = 0;
        while (hl_gto_rcvry && g < 10) begin
            step();
            g++;
            if (hl_gto_rcvry) hi++;
        end
        check("rcvry_pulse_len", hi, 4);
        check("rcvry_to_train", mgr_state, 3);

        // PLL loss reaching the FSM in the same cycle as sw_retrain.
        dl_up = 1'b1;
        step();
        check("simul_link_up", mgr_state, 4);
        ffs_plol = 1'b1;
        step();
        step();
        sw_retrain = 1'b1;
        step();
        sw_retrain = 1'b0;
        check("simul_state", mgr_state, 1);
        check("simul_core_rst_n", core_rst_n, 0);
        check("simul_hl_rcvry", hl_gto_rcvry, 0);
        check("simul_pcs_rst_n", pcs_rst_n, 1);
        check("simul_link_up_out", link_up, 0);
        check("simul_drop_cnt", link_drop_cnt, 1);
        step();
        check("simul_hl_after", hl_gto_rcvry, 0);
        ffs_plol = 1'b0;
        dl_up = 1'b0;

        // Saturation of the drop counter.
        to_err = 0;
        g = 0;
        while (mgr_state != 3'd3 && g < 1000) begin
            step();
            g++;
        end
        check("sat_reach_train", mgr_state, 3);
        for (int i = 0; i < 300; i++) begin
            dl_up = 1'b1;
            step();
            dl_up = 1'b0;
            step();
            g = 0;
            while (mgr_state != 3'd3 && g < 20) begin
                step();
                g++;
            end
            if (g >= 20) to_err++;
            if (i == 198) check("sat_cnt_200", link_drop_cnt, 200);
        end
        check("sat_timeouts", to_err, 0);
        check("sat_cnt_255", link_drop_cnt, 255);

        // Asynchronous reset in the middle of RCVRY.
        dl_up = 1'b1;
        step();
        dl_up = 1'b0;
        step();
        check("async_in_rcvry", mgr_state, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("async");

`ifdef PCIE_LINK_WDOG_EN
        // Watchdog: dl_up never rises in TRAIN.
        do_reset("wdog");
        run_to(T_CORE);
        check("wdog_train", mgr_state, 3);
        run_to(T_CORE + 62);
        check("wdog_core_held", core_rst_n, 1);
        step();
        check("wdog_core_drop", core_rst_n, 0);
        check("wdog_state_dly", mgr_state, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_link_rst_mgr.md
Name: pcie_link_rst_mgr

Overview:
Parametrised reset and link-management sequencer for ECP3 PCIe x1/x2/x4 evaluation tops. It sits between the board reset pin, the PCS/SERDES PIPE wrapper and the PCIe core. It synchronises rst_n, sequences the PCS reset, PLL/CDR lock and the delayed core reset, and decodes LTSSM L0. It also monitors data-link-up, issues recovery requests on link loss or software request, and counts link drops.

Parameters:
NUM_LANES, 1, lane count; sets width of ffs_rlol (1, 2 or 4).
CORE_DLY_W, 20, width of core-reset delay counter; core release at bit CORE_DLY_W-1 (about 4 ms at 125 MHz).
LOCK_STABLE_CYC, 1024, consecutive clean-lock cycles required before leaving LOCK_WAIT.
LTSSM_L0, 4'd3, phy_ltssm_state encoding of L0.
RCVRY_PULSE_CYC, 4, length of the hl_gto_rcvry pulse in cycles.
WDOG_W, 24, width of training watchdog counter (optional feature only).

Ports:
sys_clk_125  in  1  125 MHz core clock (PCLK_by_2 from PCS).
rst_n  in  1  asynchronous, active-low board reset.
ffs_plol  in  1  PCS PLL loss of lock, active-high, asynchronous.
ffs_rlol  in  NUM_LANES  per-lane CDR loss of lock, active-high, asynchronous.
phy_ltssm_state  in  4  LTSSM state from core.
dl_up  in  1  data link layer up from core.
sw_retrain  in  1  single-cycle software retrain request.
pcs_rst_n  out  1  reset to PIPE wrapper.
core_rst_n  out  1  delayed reset to PCIe core and user logic.
phy_l0  out  1  registered (phy_ltssm_state == LTSSM_L0).
hl_gto_rcvry  out  1  recovery request pulse to core.
link_up  out  1  registered dl_up, qualified by the LINK_UP state.
link_drop_cnt  out  8  saturating count of dl_up falling edges seen in LINK_UP.
mgr_state  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset rst_n is asynchronous, active-low; clock is sys_clk_125. rst_n is re-synchronised by a 2-flop chain (assert async, deassert sync). Every sequential element resets from the synchronised reset.
- ffs_plol and ffs_rlol are each double-flopped. lock_ok = !plol_s && !(|rlol_s).
- Outputs under reset: pcs_rst_n=0, core_rst_n=0, phy_l0=0, hl_gto_rcvry=0, link_up=0, link_drop_cnt=0, mgr_state=RESET.
- FSM encodings: RESET=0, LOCK_WAIT=1, CORE_DLY=2, TRAIN=3, LINK_UP=4, RCVRY=5.
- RESET: lasts 1 cycle after sync reset release, then goes to LOCK_WAIT with pcs_rst_n=1.
- LOCK_WAIT: a stability counter counts while lock_ok is high and clears to 0 whenever lock_ok is low. When the counter reaches LOCK_STABLE_CYC-1, go to CORE_DLY.
- CORE_DLY: a CORE_DLY_W-bit counter increments from 0. When its MSB sets, core_rst_n goes to 1 on the next cycle and the FSM goes to TRAIN. Loss of lock here returns to LOCK_WAIT and clears the counter.
- TRAIN: dl_up=1 moves to LINK_UP.
- LINK_UP: link_up=1. On a dl_up falling edge, increment link_drop_cnt (saturate at 255) and go to RCVRY. sw_retrain=1 also goes to RCVRY, with no count.
- RCVRY: hl_gto_rcvry is held high for exactly RCVRY_PULSE_CYC cycles, then the FSM goes to TRAIN.
- In all states after CORE_DLY, loss of lock deasserts core_rst_n, clears all counters except link_drop_cnt, and returns to LOCK_WAIT. pcs_rst_n stays 1.
- Simultaneous events: loss of lock has highest priority, then dl_up falling, then sw_retrain. sw_retrain in any state other than LINK_UP is ignored.
- link_up is forced to 0 in every state except LINK_UP. phy_l0 is independent of the FSM and lags phy_ltssm_state by 1 cycle.
- Reset mid-operation: all outputs return to reset values asynchronously, including link_drop_cnt.

Optional Feature:
Macro PCIE_LINK_WDOG_EN.
- Defined: a WDOG_W-bit watchdog runs while in TRAIN. If it reaches all-ones before dl_up, core_rst_n deasserts and the FSM returns to CORE_DLY with counters cleared. link_drop_cnt is unchanged.
- Undefined: no watchdog logic is built; TRAIN waits indefinitely.

Decomposition:
- Shared package pcie_mgr_pkg holds the FSM state localparams (RESET..RCVRY), the LTSSM_L0 default, and the link_drop_cnt width constant.
- One sub-module, pcie_sync2 (2-flop synchroniser, parametrised width), is instantiated for rst_n, ffs_plol and ffs_rlol.

Test Plan:
- Power-on: rst_n low for 10 cycles, then high, locks clean. Expect pcs_rst_n=1 at cycle 3. Expect core_rst_n=1 after 3 + LOCK_STABLE_CYC + 2^(CORE_DLY_W-1) + 1 cycles, using CORE_DLY_W=8 in simulation.
- Lock glitch: ffs_rlol[1]=1 for 1 cycle at LOCK_STABLE_CYC/2, with NUM_LANES=4. Expect the stability counter to restart and CORE_DLY entry to be delayed by the full LOCK_STABLE_CYC.
- Link drop: in LINK_UP, dl_up goes 1→0. Expect link_drop_cnt 0→1, link_up=0 next cycle, hl_gto_rcvry high for exactly 4 cycles, then mgr_state=3.
- Simultaneous events: in LINK_UP, ffs_plol=1 in the same cycle as sw_retrain=1. Expect core_rst_n=0, mgr_state=1, and no hl_gto_rcvry pulse.
- Saturation: 300 link drops. Expect link_drop_cnt=255. Async rst_n mid-RCVRY: expect all outputs at reset values immediately.
- With PCIE_LINK_WDOG_EN and WDOG_W=6, dl_up held 0: expect core_rst_n to drop 63 cycles after TRAIN entry and the FSM to re-enter CORE_DLY.
